// File: rtl/adpll_lock_detector.sv
// Phase-lock qualifier on the DCO clock: measures PFD flag activity per reference period and qualifies phase_lock.
// Status outputs are registered on clk. There is no backpressure. ref/flag/freq_lock are 2-flop synchronised (ref edge seen 3 clk late).
module adpll_lock_detector #(
    parameter int W          = 8,
    parameter int ERR_TOL    = 2,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int TIMEOUT    = 200
) (
    input  logic         clk,
    input  logic         RESET_,
    input  logic         ref_clk,
    input  logic         flagU,
    input  logic         flagD,
    input  logic         freq_lock,
    output logic         phase_lock,
    output logic         lock_lost,
    output logic         ref_lost,
    output logic [W-1:0] err_width
);

    localparam int CMAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [W-1:0]  ACC_MAX = {W{1'b1}};
    localparam logic [W-1:0]  TOL     = W'(ERR_TOL);
    localparam logic [W-1:0]  TMO_END = W'(TIMEOUT - 1);
    localparam logic [CW-1:0] GOOD_N  = CW'(LOCK_CNT);
    localparam logic [CW-1:0] BAD_N   = CW'(UNLOCK_CNT);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED, HOLD} state_t;

    logic [1:0]    r_ref_sync, r_u_sync, r_d_sync, r_fl_sync;
    logic          r_ref_d;
    logic [W-1:0]  r_err_acc, r_err_width, r_tmo;
    logic          r_ref_lost, r_phase_lock, r_lock_lost;
    logic [CW-1:0] r_gcnt, r_bcnt;
    state_t        r_state;

    logic          w_ref_rise, w_flag, w_freq_ok, w_good, w_rl_rise, w_pl_nxt;
    logic [W-1:0]  w_acc_inc;
    logic [CW-1:0] w_gcnt_nxt, w_bcnt_nxt;
    state_t        w_state_nxt;

    assign w_ref_rise = r_ref_sync[1] & ~r_ref_d;
    assign w_flag     = r_u_sync[1] | r_d_sync[1];
    assign w_freq_ok  = r_fl_sync[1];
    // The sample latched on ref_rise includes the flag of that same cycle.
    assign w_acc_inc  = (r_err_acc == ACC_MAX) ? r_err_acc : r_err_acc + {{(W-1){1'b0}}, w_flag};
    assign w_good     = (w_acc_inc <= TOL);
    assign w_rl_rise  = ~w_ref_rise & ~r_ref_lost & (r_tmo == TMO_END);

    always_ff @(posedge clk or negedge RESET_) begin
        if (!RESET_) begin
            r_ref_sync <= '0;
            r_u_sync   <= '0;
            r_d_sync   <= '0;
            r_fl_sync  <= '0;
            r_ref_d    <= 1'b0;
        end else begin
            r_ref_sync <= {r_ref_sync[0], ref_clk};
            r_u_sync   <= {r_u_sync[0], flagU};
            r_d_sync   <= {r_d_sync[0], flagD};
            r_fl_sync  <= {r_fl_sync[0], freq_lock};
            r_ref_d    <= r_ref_sync[1];
        end
    end

    always_ff @(posedge clk or negedge RESET_) begin
        if (!RESET_) begin
            r_err_acc   <= '0;
            r_err_width <= '0;
            r_tmo       <= '0;
            r_ref_lost  <= 1'b0;
        end else if (w_ref_rise) begin
            r_err_width <= w_acc_inc;
            r_err_acc   <= '0;
            r_tmo       <= '0;
            r_ref_lost  <= 1'b0;
        end else begin
            r_err_acc <= w_acc_inc;
            if (r_tmo == TMO_END)
                r_ref_lost <= 1'b1;
            else
                r_tmo <= r_tmo + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gcnt_nxt  = r_gcnt;
        w_bcnt_nxt  = r_bcnt;
        if (!w_freq_ok) begin
            w_state_nxt = IDLE;
            w_gcnt_nxt  = '0;
            w_bcnt_nxt  = '0;
        end else if (w_rl_rise && (r_state != IDLE)) begin
            w_state_nxt = ACQ;
            w_gcnt_nxt  = '0;
            w_bcnt_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = ACQ;
                    w_gcnt_nxt  = '0;
                    w_bcnt_nxt  = '0;
                end
                ACQ: if (w_ref_rise) begin
                    if (!w_good)
                        w_gcnt_nxt = '0;
                    else if ((r_gcnt + 1'b1) == GOOD_N) begin
                        w_state_nxt = LOCKED;
                        w_gcnt_nxt  = '0;
                        w_bcnt_nxt  = '0;
                    end else
                        w_gcnt_nxt = r_gcnt + 1'b1;
                end
                LOCKED: if (w_ref_rise && !w_good) begin
                    if (BAD_N == CW'(1)) begin
                        w_state_nxt = ACQ;
                        w_gcnt_nxt  = '0;
                        w_bcnt_nxt  = '0;
                    end else begin
                        w_state_nxt = HOLD;
                        w_bcnt_nxt  = CW'(1);
                    end
                end
                HOLD: if (w_ref_rise) begin
                    if (w_good) begin
                        w_state_nxt = LOCKED;
                        w_bcnt_nxt  = '0;
                    end else if ((r_bcnt + 1'b1) == BAD_N) begin
                        w_state_nxt = ACQ;
                        w_gcnt_nxt  = '0;
                        w_bcnt_nxt  = '0;
                    end else
                        w_bcnt_nxt = r_bcnt + 1'b1;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_gcnt_nxt  = '0;
                    w_bcnt_nxt  = '0;
                end
            endcase
        end
        w_pl_nxt = (w_state_nxt == LOCKED) || (w_state_nxt == HOLD);
    end

    always_ff @(posedge clk or negedge RESET_) begin
        if (!RESET_) begin
            r_state      <= IDLE;
            r_gcnt       <= '0;
            r_bcnt       <= '0;
            r_phase_lock <= 1'b0;
            r_lock_lost  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_gcnt       <= w_gcnt_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_phase_lock <= w_pl_nxt;
            r_lock_lost  <= r_phase_lock & ~w_pl_nxt;
        end
    end

    assign phase_lock = r_phase_lock;
    assign lock_lost  = r_lock_lost;
    assign ref_lost   = r_ref_lost;
    assign err_width  = r_err_width;

endmodule

// File: tb/tb_adpll_lock_detector.sv
// Bench for adpll_lock_detector: vector table, randomized periods against a streak model, and hand-written corner sequences.
module tb_adpll_lock_detector;

    logic       clk = 1'b0;
    logic       RESET_, ref_clk, flagU, flagD, freq_lock;
    logic       phase_lock, lock_lost, ref_lost;
    logic [7:0] err_width;

    int checks = 0;
    int errors = 0;
    int ll_total = 0;

    adpll_lock_detector dut (
        .clk(clk), .RESET_(RESET_), .ref_clk(ref_clk), .flagU(flagU), .flagD(flagD),
        .freq_lock(freq_lock), .phase_lock(phase_lock), .lock_lost(lock_lost),
        .ref_lost(ref_lost), .err_width(err_width)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (lock_lost) ll_total++;
    end

    typedef struct {
        int         k;
        logic       exp_pl;
        int         exp_ll;
        logic [7:0] exp_ew;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One reference period: k flag-active clk cycles, a quiet gap, then a ref rising edge.
    // Returns 3 clk after the internal ref_rise, so the period's results are visible.
    task automatic period(input int k);
        ref_clk = 1'b0;
        @(negedge clk);
        if (k > 0) begin
            flagU = 1'b1;
            flagD = (k % 2 == 1);
            repeat (k) @(negedge clk);
            flagU = 1'b0;
            flagD = 1'b0;
        end
        repeat (4) @(negedge clk);
        ref_clk = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Abstract lock model: consecutive good/bad streaks.
    bit m_locked;
    int m_good, m_bad;

    function automatic bit model_step(input int k);
        bit was = m_locked;
        if (!m_locked) begin
            m_good = (k <= 2) ? m_good + 1 : 0;
            if (m_good == 16) begin
                m_locked = 1;
                m_bad    = 0;
            end
        end else begin
            m_bad = (k > 2) ? m_bad + 1 : 0;
            if (m_bad == 4) begin
                m_locked = 0;
                m_good   = 0;
            end
        end
        return was && !m_locked;
    endfunction

    initial begin
        int base, k, ll_exp;
        RESET_ = 1'b0; ref_clk = 1'b0; flagU = 1'b0; flagD = 1'b0; freq_lock = 1'b0;

        for (int i = 0; i < 24; i++) begin
            if (i < 16)       tbl[i] = '{0, (i == 15), 0, 8'd0};
            else if (i < 19)  tbl[i] = '{5, 1'b1, 0, 8'd5};
            else if (i == 19) tbl[i] = '{0, 1'b1, 0, 8'd0};
            else              tbl[i] = '{5, (i < 23), (i == 23) ? 1 : 0, 8'd5};
        end

        repeat (3) @(negedge clk);
        chk("reset_phase_lock", phase_lock, 0);
        chk("reset_lock_lost", lock_lost, 0);
        chk("reset_ref_lost", ref_lost, 0);
        chk("reset_err_width", err_width, 0);
        RESET_ = 1'b1;
        freq_lock = 1'b1;
        repeat (4) @(negedge clk);

        // Acquire, tolerate 3 bad + 1 good, then drop after 4 bad.
        for (int i = 0; i < 24; i++) begin
            base = ll_total;
            period(tbl[i].k);
            chk($sformatf("tbl%0d_phase_lock", i), phase_lock, tbl[i].exp_pl);
            chk($sformatf("tbl%0d_err_width", i), err_width, tbl[i].exp_ew);
            chk($sformatf("tbl%0d_lock_lost_cycles", i), ll_total - base, tbl[i].exp_ll);
        end

        m_locked = 0; m_good = 0; m_bad = 0;
        for (int i = 0; i < 80; i++) begin
            k = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(3, 6);
            base = ll_total;
            period(k);
            ll_exp = model_step(k) ? 1 : 0;
            chk($sformatf("rnd%0d_phase_lock", i), phase_lock, m_locked);
            chk($sformatf("rnd%0d_err_width", i), err_width, k);
            chk($sformatf("rnd%0d_lock_lost_cycles", i), ll_total - base, ll_exp);
        end

        // Reference loss while locked.
        repeat (16) period(0);
        chk("tmo_locked", phase_lock, 1);
        base = ll_total;
        repeat (196) @(negedge clk);
        chk("tmo_ref_lost_early", ref_lost, 0);
        chk("tmo_phase_lock_early", phase_lock, 1);
        @(negedge clk);
        chk("tmo_ref_lost", ref_lost, 1);
        chk("tmo_phase_lock_drop", phase_lock, 0);
        chk("tmo_lock_lost_cycles", ll_total - base, 1);
        period(0);
        chk("tmo_ref_lost_cleared", ref_lost, 0);
        chk("tmo_stays_unlocked", phase_lock, 0);

        // Frequency-lock loss, then saturation of err_width.
        repeat (16) period(0);
        chk("fl_locked", phase_lock, 1);
        base = ll_total;
        freq_lock = 1'b0;
        repeat (2) @(negedge clk);
        chk("fl_phase_lock_2clk", phase_lock, 1);
        @(negedge clk);
        chk("fl_phase_lock_3clk", phase_lock, 0);
        repeat (3) @(negedge clk);
        chk("fl_lock_lost_cycles", ll_total - base, 1);
        period(300);
        chk("sat_err_width", err_width, 255);
        chk("idle_no_lock", phase_lock, 0);

        freq_lock = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            period((i == 15) ? 2 : i % 3);
            chk($sformatf("relock%0d_phase_lock", i), phase_lock, (i == 15) ? 1 : 0);
        end
        chk("relock_err_width", err_width, 2);

        // Asynchronous reset mid-period while locked.
        ref_clk = 1'b0;
        flagU = 1'b1;
        repeat (3) @(negedge clk);
        #2 RESET_ = 1'b0;
        #1;
        chk("arst_phase_lock", phase_lock, 0);
        chk("arst_lock_lost", lock_lost, 0);
        chk("arst_ref_lost", ref_lost, 0);
        chk("arst_err_width", err_width, 0);
        flagU = 1'b0;
        @(negedge clk);
        RESET_ = 1'b1;
        for (int i = 0; i < 16; i++) begin
            period(1);
            chk($sformatf("post_rst%0d_phase_lock", i), phase_lock, (i == 15) ? 1 : 0);
            if (i == 0) chk("post_rst_first_err_width", err_width, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
